// File: rtl/raster_cmd_scheduler_if.sv
// Bundle between the command requesters, the scheduler and the 8x8 rasterizer.
// The scheduler connects through the slave modport; the driving side
// (pin decoder / host / rasterizer model) uses master.
interface raster_cmd_scheduler_if #(
    parameter int FIFO_DEPTH = 4
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          a_valid;
    logic          a_ready;
    logic [19:0]   a_pkt;
    logic          b_valid;
    logic          b_ready;
    logic [19:0]   b_pkt;
    logic [1:0]    r_cmd;
    logic [17:0]   r_args;
    logic          r_frame_sync;
    logic          busy;
    logic [CW-1:0] fifo_count;
    logic          done_pulse;
    logic          err_timeout;

    modport master (
        output a_valid, a_pkt, b_valid, b_pkt, r_frame_sync,
        input  a_ready, b_ready, r_cmd, r_args, busy, fifo_count,
               done_pulse, err_timeout
    );

    modport slave (
        input  a_valid, a_pkt, b_valid, b_pkt, r_frame_sync,
        output a_ready, b_ready, r_cmd, r_args, busy, fifo_count,
               done_pulse, err_timeout
    );
endinterface

// File: rtl/raster_cmd_scheduler.sv
// raster_cmd_scheduler
// Round-robin arbiter for two command sources feeding a small command FIFO,
// followed by an issue FSM that sends one command at a time to the 8x8
// rasterizer as a single-cycle r_cmd pulse, then waits for frame_sync and the
// 64-pixel output pass before issuing the next one.
// Optional feature: define SCHED_TIMEOUT_EN to abort a command whose
// frame_sync never arrives (sets sticky err_timeout).
module raster_cmd_scheduler #(
    parameter int FIFO_DEPTH     = 4,
    parameter int DRAIN_CYCLES   = 64,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                   clk,
    input  logic                   rst,
    raster_cmd_scheduler_if.slave  bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int DW = $clog2(DRAIN_CYCLES + 1);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_ISSUE     = 2'd1;
    localparam logic [1:0] ST_WAIT_SYNC = 2'd2;
    localparam logic [1:0] ST_DRAIN     = 2'd3;

    localparam logic GRANT_A = 1'b0;
    localparam logic GRANT_B = 1'b1;

    logic [19:0]   fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic [1:0]    state_reg;
    logic [1:0]    state_next;
    logic          last_grant_reg;
    logic [1:0]    cmd_hold_reg;
    logic [17:0]   args_reg;
    logic [DW-1:0] drain_cnt_reg;

    logic          full;
    logic          empty;
    logic          a_take;
    logic          b_take;
    logic          push;
    logic          pop;
    logic [19:0]   push_pkt;
    logic          timeout_hit;

    // Arbitration: no bypass at full, round-robin only matters when both ask
    assign full        = (count_reg == CW'(FIFO_DEPTH));
    assign empty       = (count_reg == '0);
    assign bus.a_ready = !full && (!bus.b_valid || last_grant_reg == GRANT_B);
    assign bus.b_ready = !full && (!bus.a_valid || last_grant_reg == GRANT_A);
    assign a_take      = bus.a_valid && bus.a_ready;
    assign b_take      = bus.b_valid && bus.b_ready;
    assign push_pkt    = a_take ? bus.a_pkt : bus.b_pkt;
    // NOP packets complete the handshake but never occupy a FIFO slot
    assign push        = (a_take && bus.a_pkt[19:18] != 2'b00) ||
                         (b_take && bus.b_pkt[19:18] != 2'b00);
    assign pop         = (state_reg == ST_IDLE) && !empty;

    // Round-robin memory of the last accepted requester
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_reg <= GRANT_B;
        end else if (a_take) begin
            last_grant_reg <= GRANT_A;
        end else if (b_take) begin
            last_grant_reg <= GRANT_B;
        end
    end

    // FIFO storage write port (no reset so it maps onto RAM)
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= push_pkt;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at power-of-2 depth
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Registered FIFO read: head lands in the r_args / held-cmd registers,
    // which then hold until the next pop
    always_ff @(posedge clk) begin
        if (rst) begin
            args_reg     <= '0;
            cmd_hold_reg <= 2'b00;
        end else if (pop) begin
            args_reg     <= fifo_mem[rd_ptr_reg][17:0];
            cmd_hold_reg <= fifo_mem[rd_ptr_reg][19:18];
        end
    end

    // Issue FSM next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:      if (!empty) state_next = ST_ISSUE;
            ST_ISSUE:     state_next = ST_WAIT_SYNC;
            ST_WAIT_SYNC: begin
                if (bus.r_frame_sync) begin
                    state_next = ST_DRAIN;
                end else if (timeout_hit) begin
                    state_next = ST_IDLE;
                end
            end
            ST_DRAIN:     if (drain_cnt_reg == '0) state_next = ST_IDLE;
            default:      state_next = ST_IDLE;
        endcase
    end

    // Issue FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Output-pass counter: the frame_sync cycle is the first of the pass
    always_ff @(posedge clk) begin
        if (rst) begin
            drain_cnt_reg <= '0;
        end else if (state_reg == ST_WAIT_SYNC && bus.r_frame_sync) begin
            drain_cnt_reg <= DW'(DRAIN_CYCLES - 1);
        end else if (state_reg == ST_DRAIN && drain_cnt_reg != '0) begin
            drain_cnt_reg <= drain_cnt_reg - DW'(1);
        end
    end

`ifdef SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] wait_cnt_reg;
    logic          err_timeout_reg;

    // Abort on the last allowed WAIT_SYNC cycle if frame_sync is still absent
    assign timeout_hit = (state_reg == ST_WAIT_SYNC) && !bus.r_frame_sync &&
                         (wait_cnt_reg == TW'(TIMEOUT_CYCLES - 1));

    // WAIT_SYNC cycle counter and sticky timeout flag
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_reg    <= '0;
            err_timeout_reg <= 1'b0;
        end else begin
            if (state_reg == ST_WAIT_SYNC) begin
                wait_cnt_reg <= wait_cnt_reg + TW'(1);
            end else begin
                wait_cnt_reg <= '0;
            end
            if (timeout_hit) begin
                err_timeout_reg <= 1'b1;
            end
        end
    end

    assign bus.err_timeout = err_timeout_reg;
`else
    assign timeout_hit     = 1'b0;
    assign bus.err_timeout = 1'b0;
`endif

    // r_cmd is only nonzero in ISSUE so the rasterizer never re-executes
    assign bus.r_cmd      = (state_reg == ST_ISSUE) ? cmd_hold_reg : 2'b00;
    assign bus.r_args     = args_reg;
    assign bus.busy       = (state_reg != ST_IDLE) || !empty;
    assign bus.fifo_count = count_reg;
    assign bus.done_pulse = (state_reg == ST_DRAIN) && (drain_cnt_reg == '0);

endmodule

// File: tb/tb_raster_cmd_scheduler.sv
// Self-checking bench for raster_cmd_scheduler: a table of arbitration / FIFO
// vectors, hand sequences for single issue, mid-command reset and (with
// SCHED_TIMEOUT_EN) timeout, and a randomized run against a queue-based model.
module tb_raster_cmd_scheduler;
    localparam int FIFO_DEPTH     = 4;
    localparam int DRAIN_CYCLES   = 64;
    localparam int TIMEOUT_CYCLES = 15;
    localparam int RAND_ACCEPTS   = 30;
    localparam int RAND_BUDGET    = 8000;
    localparam int NVEC           = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    raster_cmd_scheduler_if #(.FIFO_DEPTH(FIFO_DEPTH)) bus ();

    raster_cmd_scheduler #(
        .FIFO_DEPTH     (FIFO_DEPTH),
        .DRAIN_CYCLES   (DRAIN_CYCLES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        logic       av;
        logic [1:0] ac;
        logic       bv;
        logic [1:0] bc;
        logic       ear;
        logic       ebr;
        int         ecnt;
        logic [1:0] ercmd;
        logic       ebusy;
    } vec_t;

    vec_t vecs [NVEC];

    // randomized-run model state
    logic [19:0] q [$];
    logic [19:0] a_cur, b_cur, exp_pkt, pkt2;
    logic        a_pend, b_pend, last_b, in_cmd, pop_due, next_pop_due;
    logic        have_held, finished, a_acc, b_acc, exp_full, exp_done;
    logic [17:0] held_args;
    int          pushes, issues, accepted, sync_at, done_at, exp_cnt;
    int          pulses, pulse_at, extra;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_idle();
        bus.a_valid      = 1'b0;
        bus.a_pkt        = '0;
        bus.b_valid      = 1'b0;
        bus.b_pkt        = '0;
        bus.r_frame_sync = 1'b0;
    endtask

    task automatic do_reset();
        drive_idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    function automatic logic [19:0] rand_pkt();
        logic [1:0] c;
        c = ($urandom_range(0, 7) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
        return {c, 18'($urandom)};
    endfunction

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Post-reset vectors; grants alternate A,B,A,... from last_grant=B.
        vecs[0] = '{1'b1, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0, 0, 2'b00, 1'b0}; // NOP from A
        vecs[1] = '{1'b1, 2'b00, 1'b1, 2'b00, 1'b0, 1'b1, 0, 2'b00, 1'b0}; // NOP from B
        vecs[2] = '{1'b1, 2'b01, 1'b1, 2'b10, 1'b1, 1'b0, 0, 2'b00, 1'b0}; // A pushed
        vecs[3] = '{1'b1, 2'b01, 1'b1, 2'b10, 1'b0, 1'b1, 1, 2'b00, 1'b1}; // B pushed, head popped
        vecs[4] = '{1'b1, 2'b01, 1'b1, 2'b10, 1'b1, 1'b0, 1, 2'b01, 1'b1}; // A pushed, issue
        vecs[5] = '{1'b1, 2'b01, 1'b1, 2'b10, 1'b0, 1'b1, 2, 2'b00, 1'b1};
        vecs[6] = '{1'b1, 2'b01, 1'b1, 2'b10, 1'b1, 1'b0, 3, 2'b00, 1'b1};
        vecs[7] = '{1'b1, 2'b01, 1'b1, 2'b10, 1'b0, 1'b0, 4, 2'b00, 1'b1}; // full
        vecs[8] = '{1'b1, 2'b01, 1'b0, 2'b00, 1'b0, 1'b0, 4, 2'b00, 1'b1};
        vecs[9] = '{1'b0, 2'b00, 1'b1, 2'b10, 1'b0, 1'b0, 4, 2'b00, 1'b1};

        // ---------------- table-driven arbitration / FIFO fill ----------------
        do_reset();
        check("reset_err_timeout", 32'(bus.err_timeout), 32'(0));
        check("reset_r_args", 32'(bus.r_args), 32'(0));
        for (int i = 0; i < NVEC; i++) begin
            bus.a_valid      = vecs[i].av;
            bus.a_pkt        = {vecs[i].ac, 18'(i * 1000 + 1)};
            bus.b_valid      = vecs[i].bv;
            bus.b_pkt        = {vecs[i].bc, 18'(i * 1000 + 500)};
            bus.r_frame_sync = 1'b0;
            #1;
            if (vecs[i].av) check($sformatf("vec%0d_a_ready", i), 32'(bus.a_ready), 32'(vecs[i].ear));
            if (vecs[i].bv) check($sformatf("vec%0d_b_ready", i), 32'(bus.b_ready), 32'(vecs[i].ebr));
            check($sformatf("vec%0d_fifo_count", i), 32'(bus.fifo_count), 32'(vecs[i].ecnt));
            check($sformatf("vec%0d_r_cmd", i), 32'(bus.r_cmd), 32'(vecs[i].ercmd));
            check($sformatf("vec%0d_busy", i), 32'(bus.busy), 32'(vecs[i].ebusy));
            check($sformatf("vec%0d_done", i), 32'(bus.done_pulse), 32'(0));
            $display("[TB] vec %0d a_rdy=%b b_rdy=%b cnt=%0d r_cmd=%0d",
                     i, bus.a_ready, bus.b_ready, bus.fifo_count, bus.r_cmd);
            tick();
        end

        // ---------------- single issue with frame_sync 2 cycles after issue ----
        do_reset();
        pkt2 = {2'b01, 3'd2, 3'd3, 3'd5, 3'd6, 3'd3, 3'd3};
        bus.a_valid = 1'b1;
        bus.a_pkt   = pkt2;
        #1;
        check("rst_r_cmd", 32'(bus.r_cmd), 32'(0));
        check("rst_fifo_count", 32'(bus.fifo_count), 32'(0));
        check("rst_busy", 32'(bus.busy), 32'(0));
        check("rst_a_ready", 32'(bus.a_ready), 32'(1));
        tick();
        drive_idle();
        #1;
        check("single_pop_cycle_r_cmd", 32'(bus.r_cmd), 32'(0));
        tick();
        #1;
        check("single_issue_r_cmd", 32'(bus.r_cmd), 32'(2'b01));
        check("single_issue_x1y1", 32'(bus.r_args[17:12]), 32'({3'd2, 3'd3}));
        check("single_issue_args", 32'(bus.r_args), 32'(pkt2[17:0]));
        $display("[TB] single issue r_cmd=%0d r_args=%05h", bus.r_cmd, bus.r_args);
        tick();
        #1;
        check("single_after_issue_r_cmd", 32'(bus.r_cmd), 32'(0));
        tick();
        bus.r_frame_sync = 1'b1;
        #1;
        check("single_sync_cycle_done", 32'(bus.done_pulse), 32'(0));
        tick();
        bus.r_frame_sync = 1'b0;
        pulses = 0; pulse_at = -1; extra = 0;
        for (int k = 1; k <= 70; k++) begin
            #1;
            if (bus.done_pulse) begin
                pulses++;
                if (pulse_at < 0) pulse_at = k;
            end
            if (bus.r_cmd != 2'b00) extra++;
            tick();
        end
        check("single_done_count", 32'(pulses), 32'(1));
        check("single_done_offset", 32'(pulse_at), 32'(DRAIN_CYCLES));
        check("single_no_reissue", 32'(extra), 32'(0));
        check("single_busy_end", 32'(bus.busy), 32'(0));
        check("single_args_held", 32'(bus.r_args), 32'(pkt2[17:0]));

        // ---------------- NOP and reset during DRAIN ----------------
        do_reset();
        bus.a_valid = 1'b1;
        bus.a_pkt   = {2'b00, 18'h3ffff};
        #1;
        check("nop_a_ready", 32'(bus.a_ready), 32'(1));
        tick();
        drive_idle();
        #1;
        check("nop_fifo_count", 32'(bus.fifo_count), 32'(0));
        check("nop_busy", 32'(bus.busy), 32'(0));
        for (int i = 0; i < 3; i++) begin
            bus.b_valid = 1'b1;
            bus.b_pkt   = {2'b11, 18'(i + 7)};
            tick();
        end
        drive_idle();
        bus.r_frame_sync = 1'b1;   // first WAIT_SYNC cycle of the first command
        tick();
        bus.r_frame_sync = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        #1;
        check("middrain_busy", 32'(bus.busy), 32'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("midrst_busy", 32'(bus.busy), 32'(0));
        check("midrst_fifo_count", 32'(bus.fifo_count), 32'(0));
        check("midrst_r_cmd", 32'(bus.r_cmd), 32'(0));
        check("midrst_done", 32'(bus.done_pulse), 32'(0));
        pulses = 0; extra = 0;
        for (int k = 0; k < 80; k++) begin
            #1;
            if (bus.done_pulse) pulses++;
            if (bus.r_cmd != 2'b00) extra++;
            tick();
        end
        check("midrst_no_done", 32'(pulses), 32'(0));
        check("midrst_no_issue", 32'(extra), 32'(0));

`ifdef SCHED_TIMEOUT_EN
        // ---------------- timeout: frame_sync never arrives ----------------
        // WAIT_SYNC lasts TIMEOUT_CYCLES cycles; the flag is visible the cycle after.
        do_reset();
        bus.a_valid = 1'b1;
        bus.a_pkt   = {2'b01, 18'h00111};
        tick();
        bus.a_pkt   = {2'b10, 18'h00222};
        tick();
        drive_idle();
        #1;
        check("tmo_first_issue", 32'(bus.r_cmd), 32'(2'b01));
        pulses = 0;
        for (int k = 1; k <= TIMEOUT_CYCLES + 25; k++) begin
            tick();
            #1;
            if (bus.done_pulse) pulses++;
            if (k == TIMEOUT_CYCLES) check("tmo_err_before", 32'(bus.err_timeout), 32'(0));
            if (k == TIMEOUT_CYCLES + 1) check("tmo_err_set", 32'(bus.err_timeout), 32'(1));
            if (k == TIMEOUT_CYCLES + 2) begin
                check("tmo_next_issue_cmd", 32'(bus.r_cmd), 32'(2'b10));
                check("tmo_next_issue_args", 32'(bus.r_args), 32'(18'h00222));
            end
            if (k == TIMEOUT_CYCLES + 20) check("tmo_err_sticky", 32'(bus.err_timeout), 32'(1));
        end
        check("tmo_no_done", 32'(pulses), 32'(0));
        tick();
`endif

        // ---------------- randomized run against queue model ----------------
        do_reset();
        q.delete();
        pushes = 0; issues = 0; accepted = 0;
        last_b = 1'b1; a_pend = 1'b0; b_pend = 1'b0;
        in_cmd = 1'b0; pop_due = 1'b0; have_held = 1'b0; finished = 1'b0;
        sync_at = -1; done_at = -1; held_args = '0;
        for (int cyc = 0; cyc < RAND_BUDGET && !finished; cyc++) begin
            if (!a_pend && accepted < RAND_ACCEPTS && $urandom_range(0, 2) == 0) begin
                a_pend = 1'b1;
                a_cur  = rand_pkt();
            end
            if (!b_pend && accepted < RAND_ACCEPTS && $urandom_range(0, 2) == 0) begin
                b_pend = 1'b1;
                b_cur  = rand_pkt();
            end
            bus.a_valid = a_pend;
            bus.a_pkt   = a_pend ? a_cur : 20'($urandom);
            bus.b_valid = b_pend;
            bus.b_pkt   = b_pend ? b_cur : 20'($urandom);
            // real sync at sync_at; stray syncs anywhere except the wait window
            bus.r_frame_sync = (in_cmd && cyc == sync_at) ||
                               (!(in_cmd && cyc < sync_at) && $urandom_range(0, 9) == 0);
            #1;
            exp_cnt = pushes - issues - (pop_due ? 1 : 0);
            check("rand_fifo_count", 32'(bus.fifo_count), 32'(exp_cnt));
            check("rand_issue_now", 32'(bus.r_cmd != 2'b00), 32'(pop_due));
            if (pop_due && q.size() > 0) begin
                exp_pkt = q.pop_front();
                check("rand_issue_pkt", 32'({bus.r_cmd, bus.r_args}), 32'(exp_pkt));
                $display("[TB] issue %0d cmd=%0d args=%05h cyc=%0d",
                         issues, bus.r_cmd, bus.r_args, cyc);
                issues++;
                in_cmd    = 1'b1;
                sync_at   = cyc + int'($urandom_range(1, 4));
                done_at   = sync_at + DRAIN_CYCLES;
                held_args = exp_pkt[17:0];
                have_held = 1'b1;
            end else if (have_held) begin
                check("rand_args_held", 32'(bus.r_args), 32'(held_args));
            end
            exp_full = (exp_cnt == FIFO_DEPTH);
            if (a_pend) check("rand_a_ready", 32'(bus.a_ready), 32'(!exp_full && (!b_pend || last_b)));
            if (b_pend) check("rand_b_ready", 32'(bus.b_ready), 32'(!exp_full && (!a_pend || !last_b)));
            check("rand_busy", 32'(bus.busy), 32'(exp_cnt != 0 || in_cmd));
            exp_done = in_cmd && (cyc == done_at);
            check("rand_done", 32'(bus.done_pulse), 32'(exp_done));
            next_pop_due = !in_cmd && (exp_cnt > 0);
            if (exp_done) in_cmd = 1'b0;
            a_acc = a_pend && !exp_full && (!b_pend || last_b);
            b_acc = b_pend && !exp_full && (!a_pend || !last_b);
            if (a_acc) begin
                last_b = 1'b0;
                if (a_cur[19:18] != 2'b00) begin q.push_back(a_cur); pushes++; end
                a_pend = 1'b0;
                accepted++;
            end else if (b_acc) begin
                last_b = 1'b1;
                if (b_cur[19:18] != 2'b00) begin q.push_back(b_cur); pushes++; end
                b_pend = 1'b0;
                accepted++;
            end
            pop_due  = next_pop_due;
            finished = (accepted >= RAND_ACCEPTS) && !a_pend && !b_pend &&
                       (q.size() == 0) && !in_cmd && !pop_due;
            tick();
        end
        drive_idle();
        check("rand_completed_in_budget", 32'(finished), 32'(1));
        check("rand_issued_equals_pushed", 32'(issues), 32'(pushes));
        #1;
        check("rand_final_count", 32'(bus.fifo_count), 32'(0));
        check("rand_err_timeout", 32'(bus.err_timeout), 32'(0));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
